key_debounce_reader: RTL and testbench

KEY_DEBOUNCE_READER -- requirements
Module: key_debounce_reader

---
 rtl/key_debounce_reader.sv | 130 +++++++++++++
 tb/tb_key_debounce_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_reader.sv
// Push-button reader: two-flop synchronizer, press/release debounce FSM,
// long-press detection and a modulo-256 press counter.
module key_debounce_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST,
  input  logic       F_KEY,
  output logic       KEY_LEVEL,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PULSE,
  output logic [7:0] PRESS_COUNT
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG       = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_t;

  // The sample seen on the state's entry edge counts as the first one.
  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 32'd2);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 32'd1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t      state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        ret_long_q;
  logic [31:0] db_q;
  logic [31:0] hold_q;
  logic        raw_pressed;

  assign raw_pressed = ~sync2_q;

  // Synchronizer, debounce/hold FSM and registered strobes.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= ST_IDLE;
      ret_long_q    <= 1'b0;
      db_q          <= 32'd0;
      hold_q        <= 32'd0;
      KEY_LEVEL     <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;
      PRESS_COUNT   <= 8'd0;
    end else begin
      sync1_q       <= F_KEY;
      sync2_q       <= sync1_q;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      LONG_PULSE    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (raw_pressed) begin
            state_q <= ST_PRESS_DB;
            db_q    <= 32'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (!raw_pressed) begin
            state_q <= ST_IDLE;
          end else if (db_q >= DB_LAST) begin
            state_q     <= ST_HELD;
            PRESS_PULSE <= 1'b1;
            KEY_LEVEL   <= 1'b1;
            PRESS_COUNT <= PRESS_COUNT + 8'd1;
            hold_q      <= 32'd0;
          end else begin
            db_q <= sat_inc(db_q);
          end
        end
        ST_HELD: begin
          if (!raw_pressed) begin
            state_q    <= ST_RELEASE_DB;
            ret_long_q <= 1'b0;
            db_q       <= 32'd0;
          end else if (hold_q >= LONG_LAST) begin
            state_q    <= ST_LONG;
            LONG_PULSE <= 1'b1;
            hold_q     <= sat_inc(hold_q);
          end else begin
            hold_q <= sat_inc(hold_q);
          end
        end
        ST_LONG: begin
          if (!raw_pressed) begin
            state_q    <= ST_RELEASE_DB;
            ret_long_q <= 1'b1;
            db_q       <= 32'd0;
          end else begin
            hold_q <= sat_inc(hold_q);
          end
        end
        ST_RELEASE_DB: begin
          // A re-press before release is confirmed resumes the hold untouched.
          if (raw_pressed) begin
            state_q <= ret_long_q ? ST_LONG : ST_HELD;
          end else if (db_q >= DB_LAST) begin
            state_q       <= ST_IDLE;
            RELEASE_PULSE <= 1'b1;
            KEY_LEVEL     <= 1'b0;
          end else begin
            db_q <= sat_inc(db_q);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ret_long_q <= 1'b0;
          db_q       <= 32'd0;
          hold_q     <= 32'd0;
          KEY_LEVEL  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_reader.sv
// Scoreboard bench for key_debounce_reader: each stimulus pushes the strobes it
// should cause (kind, edge number, count, level); a negedge monitor pops them.
module tb_key_debounce_reader;

  localparam int DB = 4;
  localparam int LC = 20;
  localparam logic [2:0] K_PRESS = 3'b001;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [7:0] cnt;
    logic       lvl;
  } exp_t;

  logic       FPGA_CLK = 1'b0;
  logic       FPGA_RST = 1'b1;
  logic       F_KEY    = 1'b1;
  logic       KEY_LEVEL;
  logic       PRESS_PULSE;
  logic       RELEASE_PULSE;
  logic       LONG_PULSE;
  logic [7:0] PRESS_COUNT;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_press = 0;
  int         n_rel = 0;
  logic [7:0] exp_cnt = 8'd0;

  key_debounce_reader #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC)) dut (
    .FPGA_CLK      (FPGA_CLK),
    .FPGA_RST      (FPGA_RST),
    .F_KEY         (F_KEY),
    .KEY_LEVEL     (KEY_LEVEL),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .LONG_PULSE    (LONG_PULSE),
    .PRESS_COUNT   (PRESS_COUNT)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  always @(posedge FPGA_CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [2:0] k, input int c, input logic [7:0] n, input logic l);
    exp_t e;
    e.kind = k; e.cyc = c; e.cnt = n; e.lvl = l;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FPGA_CLK);
  endtask

  task automatic press_clean();
    F_KEY = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    push_exp(K_PRESS, cyc + DB + 2, exp_cnt, 1'b1);
  endtask

  task automatic release_clean();
    F_KEY = 1'b1;
    push_exp(K_REL, cyc + DB + 2, exp_cnt, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_level"}, int'(KEY_LEVEL), 0);
    check_eq({tag, "_strobes"}, int'({LONG_PULSE, RELEASE_PULSE, PRESS_PULSE}), 0);
    check_eq({tag, "_count"}, int'(PRESS_COUNT), 0);
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge FPGA_CLK) begin
    logic [2:0] got;
    exp_t e;
    got = {LONG_PULSE, RELEASE_PULSE, PRESS_PULSE};
    if (got != 3'b000) begin
      if (PRESS_PULSE) n_press++;
      if (RELEASE_PULSE) n_rel++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_strobe", int'(got), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("strobe_kind", int'(got), int'(e.kind));
        check_eq("strobe_edge", cyc, e.cyc);
        check_eq("strobe_level", int'(KEY_LEVEL), int'(e.lvl));
        check_eq("strobe_count", int'(PRESS_COUNT), int'(e.cnt));
      end
    end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
      e = sb_q.pop_front();
      check_eq("missing_strobe_edge", cyc, e.cyc);
    end
  end

  initial begin
    int p;
    int base_press;
    int base_rel;
    tick(3);
    check_idle_outputs("reset");
    FPGA_RST = 1'b0;
    tick(5);

    // Two short lows separated by a one-cycle high: never accepted.
    F_KEY = 1'b0; tick(3);
    F_KEY = 1'b1; tick(1);
    F_KEY = 1'b0; tick(3);
    F_KEY = 1'b1; tick(12);
    check_idle_outputs("bounce");

    // Clean press, held into a long press, then released from LONG.
    p = cyc + DB + 2;
    press_clean();
    push_exp(K_LONG, p + LC, exp_cnt, 1'b1);
    tick(DB + 2 + 2);
    check_eq("press_level", int'(KEY_LEVEL), 1);
    check_eq("press_count", int'(PRESS_COUNT), 1);
    tick(28);
    release_clean();
    tick(DB + 6);
    check_eq("release_level", int'(KEY_LEVEL), 0);
    check_eq("pending_after_long", sb_q.size(), 0);

    // Release glitch inside HELD: the three edges it spans do not advance the hold.
    p = cyc + DB + 2;
    press_clean();
    push_exp(K_LONG, p + LC + 3, exp_cnt, 1'b1);
    tick(DB + 2 + 5);
    F_KEY = 1'b1; tick(2);
    F_KEY = 1'b0; tick(4);
    check_eq("glitch_level", int'(KEY_LEVEL), 1);
    tick(30);
    release_clean();
    tick(DB + 6);
    check_eq("pending_after_glitch", sb_q.size(), 0);

    // Reset while held: everything clears and the still-held key is re-accepted.
    press_clean();
    tick(DB + 2 + 3);
    FPGA_RST = 1'b1;
    tick(1);
    check_idle_outputs("rst_hold");
    FPGA_RST = 1'b0;
    exp_cnt = 8'd0;
    press_clean();
    tick(DB + 2 + 4);
    check_eq("rst_repress_level", int'(KEY_LEVEL), 1);
    check_eq("rst_repress_count", int'(PRESS_COUNT), 1);
    release_clean();
    tick(DB + 6);

    // Counter wrap from zero over 256 press/release pairs.
    FPGA_RST = 1'b1;
    tick(1);
    check_idle_outputs("rst_idle");
    FPGA_RST = 1'b0;
    exp_cnt = 8'd0;
    tick(3);
    base_press = n_press;
    base_rel = n_rel;
    for (int i = 0; i < 256; i++) begin
      press_clean();
      tick(DB + 4);
      release_clean();
      tick(DB + 4);
    end
    tick(4);
    check_eq("wrap_count", int'(PRESS_COUNT), 0);
    check_eq("wrap_presses", n_press - base_press, 256);
    check_eq("wrap_releases", n_rel - base_rel, 256);
    check_eq("pending_final", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
